wb_gpio_irq: RTL and testbench

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_irq_if.sv | 31 +++
 rtl/wb_gpio_irq.sv | 177 +++++++++++++++++
 tb/tb_wb_gpio_irq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_irq_if.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq_if
// Wishbone classic (single-beat) bus bundle for the GPIO block.
//   wb_cyc_i, wb_stb_i, wb_we_i : cycle, strobe, write enable (master -> slave)
//   wb_adr_i[11:0]              : byte address, word select in [11:2]
//   wb_dat_i[31:0]              : write data
//   wb_dat_o[31:0]              : read data (slave -> master)
//   wb_ack_o, wb_err_o          : one-cycle response pulses
//   wb_stall_o                  : pipeline stall (never asserted by this slave)
// ---------------------------------------------------------------------------
interface wb_gpio_irq_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [11:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// ---------------------------------------------------------------------------
// wb_gpio_irq
// Wishbone-attached GPIO block with per-pin edge interrupts.
//
// Word map (byte address = word * 4):
//   0 DOUT  RW     pad output values
//   1 DIN   RO     synchronised pad inputs
//   2 DIR   RW     1 = pin drives (gpio_oe_o)
//   3 IEN   RW     interrupt enable mask
//   4 ISTAT RW1C   latched edge events
//   5 IEDGE RW     1 = rising edge, 0 = falling edge
//   >5             answered with wb_err_o, no side effect
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   wb                : Wishbone slave (wb_gpio_irq_if.slave)
//   gpio_i[WIDTH]     : asynchronous pad inputs
//   gpio_o[WIDTH]     : pad outputs (DOUT)
//   gpio_oe_o[WIDTH]  : pad output enables (DIR)
//   irq_o             : level interrupt, OR(ISTAT & IEN)
//
// Build option: define WB_GPIO_IRQ_EN to include the edge detector and the
// IEN/ISTAT/IEDGE registers. Without it irq_o is 0, words 3..5 read as 0 and
// writes to them are acknowledged and dropped.
// ---------------------------------------------------------------------------
module wb_gpio_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_gpio_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [9:0] ADR_DOUT  = 10'd0;
  localparam logic [9:0] ADR_DIN   = 10'd1;
  localparam logic [9:0] ADR_DIR   = 10'd2;
  localparam logic [9:0] ADR_IEN   = 10'd3;
  localparam logic [9:0] ADR_ISTAT = 10'd4;
  localparam logic [9:0] ADR_IEDGE = 10'd5;

  logic             ack_q;
  logic             err_q;
  logic [31:0]      dat_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] ien;
  logic [WIDTH-1:0] istat;
  logic [WIDTH-1:0] iedge;

  logic             valid;
  logic             addr_ok;
  logic             wr;
  logic [9:0]       word;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_data;
  logic             unused_bits;

  // Gating with our own ack/err stops a held strobe from being served on
  // back-to-back edges; the master sees one response every other cycle.
  assign valid   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign word    = wb.wb_adr_i[11:2];
  assign addr_ok = (word <= ADR_IEDGE);
  assign wr      = valid & wb.wb_we_i & addr_ok;
  assign wdata   = wb.wb_dat_i[WIDTH-1:0];

  assign unused_bits = ^{wb.wb_dat_i, wb.wb_adr_i[1:0]};

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = 1'b0;

  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;
  assign din       = sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_data = '0;
    case (word)
      ADR_DOUT:  rd_data = dout_q;
      ADR_DIN:   rd_data = din;
      ADR_DIR:   rd_data = dir_q;
      ADR_IEN:   rd_data = ien;
      ADR_ISTAT: rd_data = istat;
      ADR_IEDGE: rd_data = iedge;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      dout_q <= '0;
      dir_q  <= '0;
    end else begin
      ack_q <= valid & addr_ok;
      err_q <= valid & ~addr_ok;
      if (valid) begin
        dat_q <= addr_ok ? 32'(rd_data) : 32'd0;
      end
      if (wr && word == ADR_DOUT) begin
        dout_q <= wdata;
      end
      if (wr && word == ADR_DIR) begin
        dir_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef WB_GPIO_IRQ_EN
  logic [WIDTH-1:0] din_d_q;
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] istat_q;
  logic [WIDTH-1:0] iedge_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] w1c;

  assign rise = din & ~din_d_q;
  assign fall = ~din & din_d_q;
  assign hit  = (rise & iedge_q) | (fall & ~iedge_q);
  assign w1c  = (wr && word == ADR_ISTAT) ? wdata : '0;

  assign ien   = ien_q;
  assign istat = istat_q;
  assign iedge = iedge_q;
  assign irq_o = |(istat_q & ien_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      din_d_q <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      iedge_q <= '0;
    end else begin
      din_d_q <= din;
      // A new event outranks a simultaneous clear so it is never lost.
      istat_q <= (istat_q & ~w1c) | hit;
      if (wr && word == ADR_IEN) begin
        ien_q <= wdata;
      end
      if (wr && word == ADR_IEDGE) begin
        iedge_q <= wdata;
      end
    end
  end
`else
  assign ien   = '0;
  assign istat = '0;
  assign iedge = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio_irq.sv
// ---------------------------------------------------------------------------
// tb_wb_gpio_irq
// Directed scenarios followed by a random phase. A cycle-level reference
// model of the register map follows every clock edge: the synchroniser is
// modelled as a history of the pad values seen at each edge, and events are
// derived from that history by the edge rules.
// ---------------------------------------------------------------------------
module tb_wb_gpio_irq;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
`ifdef WB_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  wb_gpio_irq_if wb ();

  wb_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb       (wb),
    .gpio_i   (gpio_in),
    .gpio_o   (gpio_out),
    .gpio_oe_o(gpio_oe),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] m_dout, m_dir, m_ien, m_istat, m_iedge;
  logic             m_ack, m_err;
  logic [31:0]      m_dat;
  logic [WIDTH-1:0] hist [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_ien = '0; m_istat = '0; m_iedge = '0;
    m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
    hist.delete();
    for (int i = 0; i < SYNC + 2; i++) hist.push_back('0);
  endtask

  // One clock edge: capture inputs, advance model, check outputs #1 later.
  task automatic step();
    logic             c_rst, valid, we;
    logic [9:0]       word;
    logic [31:0]      wd;
    logic [WIDTH-1:0] g, newv, oldv, set_m, w1c, rd;
    int               n;
    c_rst = rst;
    g     = gpio_in;
    we    = wb.wb_we_i;
    word  = wb.wb_adr_i[11:2];
    wd    = wb.wb_dat_i;
    valid = wb.wb_cyc_i & wb.wb_stb_i & ~m_ack & ~m_err;
    n     = hist.size();
    newv  = hist[n-SYNC];
    oldv  = hist[n-SYNC-1];
    @(posedge clk);
    if (c_rst) begin
      model_reset();
    end else begin
      set_m = IRQ_EN ? ((newv & ~oldv & m_iedge) | (~newv & oldv & ~m_iedge)) : '0;
      w1c   = '0;
      case (word)
        10'd0:   rd = m_dout;
        10'd1:   rd = newv;
        10'd2:   rd = m_dir;
        10'd3:   rd = m_ien;
        10'd4:   rd = m_istat;
        10'd5:   rd = m_iedge;
        default: rd = '0;
      endcase
      m_ack = valid && (word <= 10'd5);
      m_err = valid && (word > 10'd5);
      if (valid) m_dat = (word <= 10'd5) ? 32'(rd) : 32'd0;
      if (valid && we && word <= 10'd5) begin
        case (word)
          10'd0: m_dout = wd[WIDTH-1:0];
          10'd2: m_dir  = wd[WIDTH-1:0];
          10'd3: if (IRQ_EN) m_ien   = wd[WIDTH-1:0];
          10'd4: if (IRQ_EN) w1c     = wd[WIDTH-1:0];
          10'd5: if (IRQ_EN) m_iedge = wd[WIDTH-1:0];
          default: ;
        endcase
      end
      m_istat = (m_istat & ~w1c) | set_m;
      hist.push_back(g);
      void'(hist.pop_front());
    end
    #1;
    chk("ack",   32'(wb.wb_ack_o),   32'(m_ack));
    chk("err",   32'(wb.wb_err_o),   32'(m_err));
    chk("dat_o", wb.wb_dat_o,        m_dat);
    chk("gpio_o",  32'(gpio_out),    32'(m_dout));
    chk("gpio_oe", 32'(gpio_oe),     32'(m_dir));
    chk("irq",   32'(irq),           32'(|(m_istat & m_ien)));
    chk("stall", 32'(wb.wb_stall_o), 32'd0);
  endtask

  task automatic bus(input logic we, input logic [11:0] adr, input logic [31:0] d);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = d;
    step();
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int         lat;
    logic [3:0] ackv;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
    model_reset();

    // Reset state
    rst = 1'b1;
    idle(3);
    chk("rst_gpio_o", 32'(gpio_out), 32'd0);
    chk("rst_dat_o", wb.wb_dat_o, 32'd0);
    rst = 1'b0;
    idle(2);

    // DOUT / DIR write and readback
    bus(1'b1, 12'h000, 32'h0000_005A);
    bus(1'b1, 12'h008, 32'h0000_00FF);
    chk("dout_pin", 32'(gpio_out), 32'h5A);
    chk("dir_pin", 32'(gpio_oe), 32'hFF);
    bus(1'b0, 12'h000, 32'h0);
    chk("dout_rd", wb.wb_dat_o, 32'h0000_005A);
    bus(1'b1, 12'h000, 32'hFFFF_FF00);
    chk("dout_upper_ignored", 32'(gpio_out), 32'h00);

    // Rising-edge latency and W1C
    bus(1'b1, 12'h014, 32'hFF);
    bus(1'b1, 12'h00C, 32'h01);
    gpio_in = 8'h81;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (irq === 1'b1 && lat == 0) lat = i;
    end
    chk("irq_latency", 32'(lat), IRQ_EN ? 32'(SYNC + 1) : 32'd0);
    bus(1'b0, 12'h010, 32'h0);
    chk("istat_rd", wb.wb_dat_o, IRQ_EN ? 32'h81 : 32'h0);
    bus(1'b1, 12'h010, 32'h01);
    bus(1'b0, 12'h010, 32'h0);
    chk("istat_w1c", wb.wb_dat_o, IRQ_EN ? 32'h80 : 32'h0);
    bus(1'b0, 12'h004, 32'h0);
    chk("din_rd", wb.wb_dat_o, 32'h81);

    // Falling edge colliding with W1C of the same bit
    bus(1'b1, 12'h014, 32'h00);
    gpio_in = 8'h89; idle(4);
    gpio_in = 8'h81; idle(4);
    gpio_in = 8'h89; idle(4);
    gpio_in = 8'h81;
    idle(SYNC);
    bus(1'b1, 12'h010, 32'h08);
    bus(1'b0, 12'h010, 32'h0);
    chk("set_beats_clear", 32'(wb.wb_dat_o[3]), 32'(IRQ_EN));

    // Out-of-range access
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 12'h018;
    step();
    chk("oor_err", 32'(wb.wb_err_o), 32'd1);
    chk("oor_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("oor_dat", wb.wb_dat_o, 32'd0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    step();
    chk("oor_err_drop", 32'(wb.wb_err_o), 32'd0);
    bus(1'b1, 12'h018, 32'hFFFF_FFFF);
    chk("oor_no_effect", 32'(gpio_out), 32'h00);

    // Held strobe: one response every other cycle
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 12'h008;
    for (int i = 0; i < 4; i++) begin
      step();
      ackv[i] = wb.wb_ack_o;
    end
    chk("held_ack_pattern", 32'(ackv), 32'b0101);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    step();

    // Reset while an access is in flight
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 12'h000; wb.wb_dat_i = 32'h33;
    rst = 1'b1;
    step();
    chk("rst_flight_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("rst_flight_oe", 32'(gpio_oe), 32'd0);
    chk("rst_flight_irq", 32'(irq), 32'd0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    step();
    rst = 1'b0;
    idle(4);

    // IEN readback / interrupt with pins toggling
    bus(1'b1, 12'h00C, 32'hFF);
    bus(1'b1, 12'h014, 32'h0F);
    for (int i = 0; i < 6; i++) begin
      gpio_in = ~gpio_in;
      idle(2);
    end
    bus(1'b0, 12'h00C, 32'h0);
    chk("ien_rd", wb.wb_dat_o, IRQ_EN ? 32'hFF : 32'h0);

    // Random phase
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) gpio_in = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: step();
        1: begin
          wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b0;
          step();
          wb.wb_cyc_i = 1'b0;
        end
        default: begin
          logic [11:0] a;
          a = {7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
          wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
          wb.wb_we_i  = 1'($urandom);
          wb.wb_adr_i = a;
          wb.wb_dat_i = $urandom;
          step();
          if ($urandom_range(0, 1) == 0) begin
            wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
          end
        end
      endcase
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
